// File: rtl/boundary_exchange_unit_pkg.sv
// Shared definitions for the boundary exchange path: global stage encoding,
// exchange FSM states and the flit-count helper used on both FPGAs.
package boundary_exchange_unit_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW         = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE        = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING      = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = 3'd5;

    typedef enum logic [1:0] {
        XCHG_IDLE,
        XCHG_ACTIVE,
        XCHG_DONE
    } xchg_state_t;

    // Both link partners call this so they agree on the flit count.
    function automatic int num_flits(input int payload_width, input int link_width);
        return (payload_width + link_width - 1) / link_width;
    endfunction

endpackage

// File: rtl/boundary_exchange_unit_if.sv
// Inter-FPGA flit link: one valid/ready channel in each direction.
interface boundary_exchange_unit_if #(
    parameter int LINK_WIDTH = 4
);
    logic [LINK_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [LINK_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/boundary_exchange_unit_link_flit_serializer.sv
// Loads one payload word and emits it LSB-first as LINK_WIDTH-bit flits,
// advancing only on a valid/ready handshake.
module boundary_exchange_unit_link_flit_serializer #(
    parameter int PAYLOAD_WIDTH = 10,
    parameter int LINK_WIDTH    = 4,
    parameter int NUM_FLITS     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     active,
    input  logic [PAYLOAD_WIDTH-1:0] payload,
    input  logic                     ready,
    output logic [LINK_WIDTH-1:0]    data,
    output logic                     valid,
    output logic                     done
);
    localparam int SHIFT_W = NUM_FLITS * LINK_WIDTH;
    localparam int CNT_W   = $clog2(NUM_FLITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS);

    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= SHIFT_W'(payload);
            cnt_q   <= '0;
        end else if (valid && ready) begin
            shift_q <= shift_q >> LINK_WIDTH;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign data  = shift_q[LINK_WIDTH-1:0];
    assign valid = active && (cnt_q < LAST);
    assign done  = (cnt_q == LAST);

endmodule

// File: rtl/boundary_exchange_unit.sv
// Swaps one boundary PE word with the neighbouring FPGA and presents the far
// side's word, registered and stable, to the support PE.
module boundary_exchange_unit
    import boundary_exchange_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int LINK_WIDTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STAGE_WIDTH-1:0]       global_stage,
    input  logic                         start,
    input  logic [ADDRESS_WIDTH+2:0]     local_data,
    input  logic                         local_do_not_store,
    boundary_exchange_unit_if.master     link,
    output logic [ADDRESS_WIDTH+2:0]     spu_data,
    output logic                         spu_do_not_store,
    output logic                         exchange_done,
    output logic                         exchange_error
);
    localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3;
    localparam int PAYLOAD_WIDTH     = EXPOSED_DATA_SIZE + 1;
    localparam int NUM_FLITS         = num_flits(PAYLOAD_WIDTH, LINK_WIDTH);
    localparam int BUF_W             = NUM_FLITS * LINK_WIDTH;
    localparam int CNT_W             = $clog2(NUM_FLITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS);

    xchg_state_t        state_q, state_nxt;
    logic               load, spu_load, err_set;
    logic               tx_done, rx_done;
    logic [BUF_W-1:0]   rx_buf_q;
    logic [CNT_W-1:0]   rx_cnt_q;

    boundary_exchange_unit_link_flit_serializer #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .LINK_WIDTH    (LINK_WIDTH),
        .NUM_FLITS     (NUM_FLITS)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .active  (state_q == XCHG_ACTIVE),
        .payload ({local_do_not_store, local_data}),
        .ready   (link.tx_ready),
        .data    (link.tx_data),
        .valid   (link.tx_valid),
        .done    (tx_done)
    );

    assign link.rx_ready = (state_q == XCHG_ACTIVE) && (rx_cnt_q < LAST);
    assign rx_done       = (rx_cnt_q == LAST);
    assign exchange_done = (state_q == XCHG_DONE);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= XCHG_IDLE;
        else        state_q <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        spu_load  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            XCHG_IDLE, XCHG_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = XCHG_ACTIVE;
                end
            end
            XCHG_ACTIVE: begin
                // A restart or an early write stage is flagged but never acted on.
                err_set = start || (global_stage == STAGE_WRITE_TO_MEM);
                if (tx_done && rx_done) begin
                    spu_load  = 1'b1;
                    state_nxt = XCHG_DONE;
                end
            end
            default: state_nxt = XCHG_IDLE;
        endcase
    end

    // NOTE: the small rx buffer is reset like any register so an aborted
    // exchange leaves no stale flits behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_buf_q <= '0;
            rx_cnt_q <= '0;
        end else if (load) begin
            rx_cnt_q <= '0;
        end else if (link.rx_valid && link.rx_ready) begin
            rx_buf_q[rx_cnt_q*LINK_WIDTH +: LINK_WIDTH] <= link.rx_data;
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            spu_data         <= '0;
            spu_do_not_store <= 1'b0;
            exchange_error   <= 1'b0;
        end else begin
            if (spu_load) {spu_do_not_store, spu_data} <= rx_buf_q[PAYLOAD_WIDTH-1:0];
            if (err_set)  exchange_error <= 1'b1;
        end
    end

    // Pad bits of the top received flit carry no information.
    generate
        if (BUF_W > PAYLOAD_WIDTH) begin : g_pad
            logic unused_rx_pad;
            assign unused_rx_pad = ^rx_buf_q[BUF_W-1:PAYLOAD_WIDTH];
        end
    endgenerate

endmodule

// File: doc/boundary_exchange_unit.md
Name: boundary_exchange_unit

Overview:
Sits directly upstream of support_processing_unit on each inter-FPGA boundary. On a start command, it captures the local boundary PE's exposed data and ships it to the neighbouring FPGA as LINK_WIDTH-bit flits over a valid/ready link. At the same time it receives the far side's flits and reassembles them. The result is presented, registered and stable, as input_data and do_not_store of the support PE. The controller enters STAGE_WRITE_TO_MEM (one cycle) only after exchange_done is high.

Parameters:
ADDRESS_WIDTH, 6, PE address width; EXPOSED_DATA_SIZE = ADDRESS_WIDTH+3
LINK_WIDTH, 4, inter-FPGA flit width in bits
(derived) PAYLOAD_WIDTH = EXPOSED_DATA_SIZE+1; NUM_FLITS = ceil(PAYLOAD_WIDTH/LINK_WIDTH)

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-low (0 = reset)
global_stage  input  STAGE_WIDTH  current global stage
start  input  1  one-cycle pulse from controller: begin exchange
local_data  input  EXPOSED_DATA_SIZE  exposed data of local boundary PE
local_do_not_store  input  1  flag sent to far side with local_data
tx_data  output  LINK_WIDTH  outgoing flit
tx_valid  output  1  outgoing flit valid
tx_ready  input  1  far side accepts flit
rx_data  input  LINK_WIDTH  incoming flit
rx_valid  input  1  incoming flit valid
rx_ready  output  1  this block accepts incoming flit
spu_data  output  EXPOSED_DATA_SIZE  to support PE input_data
spu_do_not_store  output  1  to support PE do_not_store
exchange_done  output  1  level; exchange complete, spu_* valid
exchange_error  output  1  sticky protocol error

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; counters and buffers cleared. Applies mid-exchange; partial data is discarded.
- Payload word = {do_not_store, data}. Flits are sent LSB-first, flit k = payload[k*LINK_WIDTH +: LINK_WIDTH]. Tx pads the top flit with zeros; rx ignores the pad bits.
- FSM IDLE/XCHG/DONE.
- IDLE:
  - start=1 -> latch {local_do_not_store, local_data} into the tx shift register; tx_cnt=rx_cnt=0; go to XCHG.
  - tx_valid is high on the cycle after start (registered).
- XCHG:
  - tx_valid = (tx_cnt<NUM_FLITS). On tx_valid&tx_ready, shift by LINK_WIDTH and increment tx_cnt. tx_data is held while not ready.
  - rx_ready = (rx_cnt<NUM_FLITS). On rx_valid&rx_ready, store the flit in slot rx_cnt and increment rx_cnt.
  - tx and rx are independent and may complete in either order or on the same cycle.
  - When both counts reach NUM_FLITS (including the cycle of the final handshake), load spu_data/spu_do_not_store from the rx buffer and go to DONE on the next edge. spu_* and exchange_done update together.
- DONE: exchange_done=1; tx_valid=rx_ready=0. start -> new exchange as from IDLE; exchange_done drops on the next edge.
- spu_data and spu_do_not_store change only on the DONE load or on reset. They hold between exchanges, so the single-cycle STAGE_WRITE_TO_MEM always samples stable values.
- exchange_error is set (sticky until reset) when either occurs:
  - start while in XCHG: start is ignored and the exchange continues;
  - global_stage==STAGE_WRITE_TO_MEM while in XCHG: spu_* are not updated early.
- Minimum latency, start to exchange_done with ready/valid always high: NUM_FLITS+2 cycles.

Decomposition:
- Shared package (parameters.sv): STAGE_* constants (existing), and a NUM_FLITS ceil-div function so the far-side block derives the same flit count.
- One natural sub-module: link_flit_serializer (load, shift-on-handshake, count, tx_valid). The deserializer stays inline.

Test Plan:
ADDRESS_WIDTH=6, LINK_WIDTH=4, so NUM_FLITS=3.
1. Hold reset=0 for 2 cycles with rx_valid=1 -> all outputs 0, rx_ready=0.
2. Start with local_data=0x1A5, dns=0, tx_ready=1 -> tx flits 0x5, 0xA, 0x1 on cycles 1-3. Rx flits 0x3, 0xC, 0x2 -> spu_data=0x0C3, spu_do_not_store=1, exchange_done high on cycle 5.
3. As 2, but tx_ready=0 for 5 cycles after flit 0 -> tx_data stays 0x5 with tx_valid=1; exchange_done is delayed exactly 5 cycles.
4. Rx flits complete on cycles 1-3 while tx_ready is held low until cycle 6 -> rx_ready falls after the 3rd rx flit; exchange_done only after the last tx handshake.
5. Second start mid-XCHG, then global_stage=STAGE_WRITE_TO_MEM mid-XCHG -> exchange_error=1 and stays 1. The exchange still completes with the correct spu_data.
6. reset=0 after one tx flit -> next cycle IDLE, tx_valid=0, spu_data=0. A new start then performs a clean 3-flit exchange.
